sync_fifo_wr_arbiter: RTL and testbench

- Shares the write port of one `sync_fifo` among NUM_SRC producers, each with its own valid/ready/data interface.
- Round-robin arbitration with burst locking: an owner keeps the grant for up to MAX_BURST consecutive beats while it stays valid.
- One registered output stage drives the FIFO slave port (`i_valid_s`/`i_datain` of the FIFO). Each beat is tagged with its source id.
- Sits between the producer blocks and `sync_fifo`, inside the FIFO subsystem.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 43 ++++
 rtl/sync_fifo_wr_arbiter.sv | 94 +++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync_fifo subsystem.
// Imported by the write arbiter and its round-robin picker.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Source-id width that never collapses to zero bits.
    function automatic int src_id_width(input int num_src);
        return (num_src < 2) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: the first request after 'owner' wins, and the owner is searched last.
// Works by rotating the requests, isolating the lowest set bit, then rotating back.
module rr_priority_pick
    import sync_fifo_pkg::*;
#(
    parameter  int NUM_SRC  = 4,
    localparam int SRC_ID_W = src_id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]  req,
    input  logic [SRC_ID_W-1:0] owner,
    output logic [NUM_SRC-1:0]  grant,
    output logic [SRC_ID_W-1:0] grant_idx,
    output logic                any_valid
);

    logic [SRC_ID_W-1:0] shift;
    logic [NUM_SRC-1:0]  req_rot;
    logic [NUM_SRC-1:0]  pick_rot;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        shift     = '0;
        req_rot   = '0;
        pick_rot  = '0;
        grant     = '0;
        grant_idx = '0;
        any_valid = |req;

        // Bit 0 of the rotated vector is source owner+1.
        if (owner != SRC_ID_W'(NUM_SRC - 1))
            shift = owner + SRC_ID_W'(1);

        req_rot  = NUM_SRC'({req, req} >> shift);
        pick_rot = req_rot & (~req_rot + NUM_SRC'(1));
        grant    = NUM_SRC'(({pick_rot, pick_rot} << shift) >> NUM_SRC);

        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i])
                grant_idx = SRC_ID_W'(i);
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Shares one sync_fifo write port among NUM_SRC producers, with round-robin arbitration,
// burst locking of up to MAX_BURST beats, and a single registered output stage.
module sync_fifo_wr_arbiter
    import sync_fifo_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int MAX_BURST  = 4,
    localparam int SRC_ID_W   = src_id_width(NUM_SRC),
    localparam int BURST_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_SRC-1:0]            i_valid_s,
    output logic [NUM_SRC-1:0]            o_ready_s,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_data_s,
    output logic                          o_valid_m,
    input  logic                          i_ready_m,
    output logic [DATA_WIDTH-1:0]         o_data_m,
    output logic [SRC_ID_W-1:0]           o_src_id,
    output logic [NUM_SRC-1:0]            o_grant
);

    logic [SRC_ID_W-1:0]   owner;
    logic [BURST_W-1:0]    burst_cnt;
    logic                  active;

    logic [NUM_SRC-1:0]    owner_oh;
    logic [NUM_SRC-1:0]    pick_oh;
    logic [SRC_ID_W-1:0]   pick_idx;
    logic                  pick_any;

    logic                  load_en;
    logic                  lock;
    logic                  xfer;
    logic [NUM_SRC-1:0]    winner_oh;
    logic [SRC_ID_W-1:0]   winner_idx;
    logic [DATA_WIDTH-1:0] winner_data;

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req       (i_valid_s),
        .owner     (owner),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    assign owner_oh = NUM_SRC'(1) << owner;
    assign o_grant  = active ? owner_oh : '0;

    always_comb begin
        load_en     = !o_valid_m || i_ready_m;
        // The owner keeps the grant while it stays valid and has burst budget left.
        lock        = active && i_valid_s[owner] && (burst_cnt < BURST_W'(MAX_BURST));
        winner_oh   = lock ? owner_oh : pick_oh;
        winner_idx  = lock ? owner    : pick_idx;
        xfer        = load_en && (lock || pick_any);
        o_ready_s   = (xfer && !i_rst) ? winner_oh : '0;
        winner_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (winner_idx == SRC_ID_W'(k))
                winner_data = i_data_s[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_m <= 1'b0;
            o_data_m  <= '0;
            o_src_id  <= '0;
            owner     <= SRC_ID_W'(NUM_SRC - 1);
            burst_cnt <= '0;
            active    <= 1'b0;
        end else if (load_en) begin
            if (xfer) begin
                o_valid_m <= 1'b1;
                o_data_m  <= winner_data;
                o_src_id  <= winner_idx;
                // An expired owner that wins again by search starts a fresh burst.
                burst_cnt <= lock ? burst_cnt + BURST_W'(1) : BURST_W'(1);
                owner     <= winner_idx;
                active    <= 1'b1;
            end else begin
                o_valid_m <= 1'b0;
                burst_cnt <= '0;
                active    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Self-checking bench for sync_fifo_wr_arbiter: a per-cycle reference model predicts grants,
// and a scoreboard queue checks every beat that leaves the output stage.
module tb_sync_fifo_wr_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int DW         = 32;
    localparam int MAX_BURST  = 4;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } beat_t;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic [NUM_SRC-1:0]    i_valid_s;
    logic [NUM_SRC-1:0]    o_ready_s;
    logic [NUM_SRC*DW-1:0] i_data_s;
    logic                  o_valid_m;
    logic                  i_ready_m;
    logic [DW-1:0]         o_data_m;
    logic [1:0]            o_src_id;
    logic [NUM_SRC-1:0]    o_grant;

    int compared   = 0;
    int mismatched = 0;

    beat_t      sb[$];
    beat_t      fifo_q[$];
    logic [1:0] seen[$];
    int         prod_cnt[NUM_SRC];
    bit         fifo_mode = 0;

    int m_owner;
    int m_cnt;
    bit m_active;
    bit m_valid;

    sync_fifo_wr_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid_s (i_valid_s),
        .o_ready_s (o_ready_s),
        .i_data_s  (i_data_s),
        .o_valid_m (o_valid_m),
        .i_ready_m (i_ready_m),
        .o_data_m  (o_data_m),
        .o_src_id  (o_src_id),
        .o_grant   (o_grant)
    );

    always #5 i_clk = ~i_clk;

    // Producer k presents 0xA0 + (k << 16) + number of beats already accepted from it.
    task automatic drive_data();
        for (int k = 0; k < NUM_SRC; k++)
            i_data_s[k*DW +: DW] = 32'h0000_00A0 + (32'(k) << 16) + 32'(prod_cnt[k]);
    endtask

    task automatic model_reset();
        m_owner  = NUM_SRC - 1;
        m_cnt    = 0;
        m_active = 0;
        m_valid  = 0;
        sb.delete();
        seen.delete();
        fifo_q.delete();
        for (int k = 0; k < NUM_SRC; k++) prod_cnt[k] = 0;
        drive_data();
    endtask

    task automatic apply_reset();
        i_valid_s = '0;
        i_ready_m = 1'b1;
        fifo_mode = 0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_reset();
    endtask

    // One clock: check at the falling edge, advance the model, return at rising edge + 1.
    task automatic cycle();
        bit               load_en;
        bit               lock;
        int               w;
        logic [NUM_SRC-1:0] exp_ready;
        logic [NUM_SRC-1:0] exp_grant;
        beat_t            b;
        @(negedge i_clk);
        load_en = !m_valid || i_ready_m;
        lock    = m_active && i_valid_s[m_owner] && (m_cnt < MAX_BURST);
        w       = -1;
        if (load_en) begin
            if (lock) w = m_owner;
            else begin
                for (int k = 1; k <= NUM_SRC; k++) begin
                    int idx = (m_owner + k) % NUM_SRC;
                    if (w < 0 && i_valid_s[idx]) w = idx;
                end
            end
        end
        exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0;
        exp_grant = m_active ? 4'(1 << m_owner) : 4'b0;

        compared++;
        if (o_ready_s !== exp_ready) begin
            mismatched++;
            $display("FAIL ready_s @%0t: got %b expected %b", $time, o_ready_s, exp_ready);
        end
        compared++;
        if (o_valid_m !== m_valid) begin
            mismatched++;
            $display("FAIL valid_m @%0t: got %b expected %b", $time, o_valid_m, m_valid);
        end
        compared++;
        if (o_grant !== exp_grant) begin
            mismatched++;
            $display("FAIL grant @%0t: got %b expected %b", $time, o_grant, exp_grant);
        end

        if (o_valid_m && i_ready_m) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL beat @%0t: unexpected beat src %0d data %h", $time, o_src_id, o_data_m);
            end else begin
                b = sb.pop_front();
                if (o_src_id !== b.src || o_data_m !== b.data) begin
                    mismatched++;
                    $display("FAIL beat @%0t: got src %0d data %h expected src %0d data %h",
                             $time, o_src_id, o_data_m, b.src, b.data);
                end
            end
            seen.push_back(o_src_id);
            if (fifo_mode) fifo_q.push_back('{src: o_src_id, data: o_data_m});
        end

        if (load_en) begin
            if (w >= 0) begin
                sb.push_back('{src: 2'(w), data: i_data_s[w*DW +: DW]});
                m_cnt    = lock ? m_cnt + 1 : 1;
                m_owner  = w;
                m_active = 1;
                m_valid  = 1;
            end else begin
                m_valid  = 0;
                m_active = 0;
                m_cnt    = 0;
            end
        end
        for (int k = 0; k < NUM_SRC; k++)
            if (o_ready_s[k] && i_valid_s[k]) prod_cnt[k]++;

        @(posedge i_clk);
        #1;
        drive_data();
        if (fifo_mode) i_ready_m = (fifo_q.size() < FIFO_DEPTH);
    endtask

    task automatic test_reset();
        i_rst     = 1'b1;
        i_valid_s = 4'b1111;
        i_ready_m = 1'b1;
        model_reset();
        #2;
        compared++;
        if (o_ready_s !== 4'b0 || o_valid_m !== 1'b0 || o_grant !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_hold: ready %b valid %b grant %b expected all zero", o_ready_s, o_valid_m, o_grant);
        end
        compared++;
        if (o_data_m !== '0 || o_src_id !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_data: data %h src %0d expected 0", o_data_m, o_src_id);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        i_valid_s = 4'b0000;
        #1;
        compared++;
        if (o_valid_m !== 1'b0 || o_data_m !== '0 || o_grant !== 4'b0 || o_ready_s !== 4'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: valid %b data %h grant %b ready %b expected zero",
                     o_valid_m, o_data_m, o_grant, o_ready_s);
        end
        i_valid_s = 4'b0001;
        cycle();
        compared++;
        if (o_valid_m !== 1'b1 || o_data_m !== 32'h0000_00A0 || o_src_id !== 2'd0) begin
            mismatched++;
            $display("FAIL first_beat: valid %b data %h src %0d expected 1 000000a0 0", o_valid_m, o_data_m, o_src_id);
        end
        i_valid_s = 4'b0000;
        cycle();
        cycle();
    endtask

    task automatic test_burst_lock();
        logic [1:0] exp_seq[10];
        exp_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        apply_reset();
        i_valid_s = 4'b0110;
        for (int c = 0; c < 11; c++) cycle();
        compared++;
        if (seen.size() < 10) begin
            mismatched++;
            $display("FAIL burst_lock_count: got %0d beats expected at least 10", seen.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (seen[i] !== exp_seq[i]) begin
                    mismatched++;
                    $display("FAIL burst_lock_seq[%0d]: got %0d expected %0d", i, seen[i], exp_seq[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_early_release();
        logic [1:0] exp_seq[7];
        exp_seq = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        apply_reset();
        i_valid_s = 4'b1001;
        cycle();
        cycle();
        i_valid_s = 4'b1000;
        cycle();
        i_valid_s = 4'b1001;
        for (int c = 0; c < 6; c++) cycle();
        compared++;
        if (seen.size() < 7) begin
            mismatched++;
            $display("FAIL early_release_count: got %0d beats expected at least 7", seen.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (seen[i] !== exp_seq[i]) begin
                    mismatched++;
                    $display("FAIL early_release_seq[%0d]: got %0d expected %0d", i, seen[i], exp_seq[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [1:0]    exp_seq[8];
        logic [DW-1:0] held;
        exp_seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        apply_reset();
        i_valid_s = 4'b1100;
        cycle();
        cycle();
        held      = o_data_m;
        i_ready_m = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            compared++;
            if (o_valid_m !== 1'b1 || o_data_m !== held || o_src_id !== 2'd2 || o_ready_s !== 4'b0) begin
                mismatched++;
                $display("FAIL stall[%0d]: valid %b data %h src %0d ready %b expected 1 %h 2 0000",
                         c, o_valid_m, o_data_m, o_src_id, o_ready_s, held);
            end
        end
        i_ready_m = 1'b1;
        for (int c = 0; c < 8; c++) cycle();
        compared++;
        if (seen.size() < 8) begin
            mismatched++;
            $display("FAIL back_pressure_count: got %0d beats expected at least 8", seen.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (seen[i] !== exp_seq[i]) begin
                    mismatched++;
                    $display("FAIL back_pressure_seq[%0d]: got %0d expected %0d", i, seen[i], exp_seq[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        beat_t b;
        logic [1:0] exp_src[FIFO_DEPTH];
        int         exp_cnt[FIFO_DEPTH];
        exp_src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        exp_cnt = '{0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        fifo_mode = 1;
        i_valid_s = 4'b1111;
        for (int c = 0; c < 20; c++) cycle();
        compared++;
        if (fifo_q.size() != FIFO_DEPTH || o_ready_s !== 4'b0 || o_valid_m !== 1'b1) begin
            mismatched++;
            $display("FAIL fifo_full: stored %0d ready %b valid %b expected %0d 0000 1",
                     fifo_q.size(), o_ready_s, o_valid_m, FIFO_DEPTH);
        end
        for (int i = 0; i < FIFO_DEPTH && fifo_q.size() > 0; i++) begin
            b = fifo_q.pop_front();
            compared++;
            if (b.src !== exp_src[i] || b.data !== 32'h0000_00A0 + (32'(exp_src[i]) << 16) + 32'(exp_cnt[i])) begin
                mismatched++;
                $display("FAIL fifo_read[%0d]: got src %0d data %h expected src %0d", i, b.src, b.data, exp_src[i]);
            end
        end
        fifo_mode = 0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        i_valid_s = 4'b1111;
        cycle();
        cycle();
        cycle();
        #2 i_rst = 1'b1;
        #1;
        compared++;
        if (o_valid_m !== 1'b0 || o_data_m !== '0 || o_src_id !== 2'd0 || o_grant !== 4'b0 || o_ready_s !== 4'b0) begin
            mismatched++;
            $display("FAIL mid_burst_reset: valid %b data %h src %0d grant %b ready %b expected zero",
                     o_valid_m, o_data_m, o_src_id, o_grant, o_ready_s);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_reset();
        cycle();
        compared++;
        if (o_valid_m !== 1'b1 || o_src_id !== 2'd0 || o_data_m !== 32'h0000_00A0) begin
            mismatched++;
            $display("FAIL post_reset_priority: valid %b src %0d data %h expected 1 0 000000a0",
                     o_valid_m, o_src_id, o_data_m);
        end
        i_valid_s = 4'b0000;
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_burst_lock();
        test_early_release();
        test_back_pressure();
        test_fifo_full();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
